fc_classifier_seq: RTL and testbench
====================================

Name: fc_classifier_seq

Overview:
- Downstream neighbour of the 2x2 max-pool stage. Consumes the pooled feature vector (CI x 4 x 4 words, 32 bits each) on a single valid pulse.
- Computes NUM_OUT fully-connected dot products sequentially, one MAC per clock, using an external synchronous weight ROM.
- Emits all NUM_OUT scores plus the argmax class index, which the Braille character decode logic uses.

Parameters:
CI, 3, input channels (from defines_cnn_core.vh)
IN_W, 32, bits per pooled feature word, unsigned
W_W, 8, bits per weight, signed two's complement
NUM_OUT, 10, number of FC outputs (classes)
FC_IN, CI*16, dot-product length (48 at default)
ACC_W, 48, accumulator/score width, signed
ADDR_W, clog2(NUM_OUT*FC_IN), weight address width (9 at default)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  reset; one clock; synchronous, active-low
i_in_valid  in  1  one-cycle pulse; i_in_fmap valid
i_in_fmap  in  CI*4*4*IN_W  pooled vector; element idx=ci*16+row*4+col at [IN_W*idx +: IN_W]
o_busy  out  1  high while computing; pulses on i_in_valid are ignored while high
o_w_en  out  1  weight ROM read enable
o_w_addr  out  ADDR_W  weight address = o*FC_IN + idx
i_w_data  in  W_W  ROM data; valid exactly 1 cycle after the address edge
o_ot_valid  out  1  one-cycle pulse; results updated
o_ot_fc  out  NUM_OUT*ACC_W  score o at [ACC_W*o +: ACC_W]
o_ot_class  out  clog2(NUM_OUT)  index of max score

Behaviour:
- Reset (reset_n=0 at an edge) clears every register. All outputs are 0 (o_busy, o_w_en, o_w_addr, o_ot_valid, o_ot_fc, o_ot_class) and the FSM goes to IDLE. Reset mid-run aborts the computation with no o_ot_valid and no partial result update.
- FSM states:
  - IDLE -> RUN on an edge E0 with i_in_valid=1. The full i_in_fmap is captured into an internal register.
  - RUN -> DRAIN after the last address (NUM_OUT*FC_IN-1) is issued.
  - DRAIN -> DONE after the last product is accumulated.
  - DONE -> IDLE after one cycle.
- RUN: o_w_en=1. The address counter advances 0..NUM_OUT*FC_IN-1, one per cycle, continuously across output boundaries with no bubbles.
- Data pipeline: data returned for address a (o, idx) is multiplied at the next edge as signed(i_w_data) x zero-extended feature[idx] and added to acc.
  - acc is cleared together with the add of idx=0 (acc <= product) for each new o.
  - When idx=FC_IN-1 is accumulated, the final acc is written to score[o].
- Argmax is updated incrementally as each score completes. Comparison is signed strict greater-than, so ties keep the lower index. score[0] initialises the argmax.
- o_ot_fc and o_ot_class registers update only at the completion of a full run. A completed result holds until the next run completes.
- Latency: with capture at edge E0, o_ot_valid is high for exactly the one cycle following edge E0+NUM_OUT*FC_IN+1 (481 at default).
- o_busy is high from the cycle after E0 until o_ot_valid is high. It is low in the o_ot_valid cycle, and an i_in_valid in that cycle is accepted (back-to-back runs).
- i_in_valid while o_busy=1 is dropped silently; the captured vector is unaffected.
- Width: the product is IN_W+W_W bits signed; the sum of 48 terms fits ACC_W=48 with no saturation or overflow.
- o_w_addr is 0 and o_w_en is 0 outside RUN.

Decomposition:
- defines_cnn_core.vh gains FC_IN, NUM_OUT, FC_W_W and FC_ACC_W alongside the existing CI.
- One sub-module, fc_mac: a registered signed multiply-accumulate with a first-term load input. It holds the product sign extension and the acc register.
- FSM, counters, capture register, score bank and argmax stay in fc_classifier_seq.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, o_w_en never 1.
- All features=1, ROM word(o,idx)=o (signed) -> score[o]=48*o; o_ot_class=9; o_ot_valid exactly 481 cycles after the capture edge; addresses 0..479 in order with no gaps.
- Feature[idx]=0xFFFFFFFF, all weights=-128 -> every score = -128*48*4294967295 = -26388279060480, no overflow; all scores equal, so class=0 (tie rule).
- Extra i_in_valid pulse mid-run with a different fmap -> ignored, scores match the first vector; a pulse in the o_ot_valid cycle starts a second run, second o_ot_valid 481 cycles later.
- reset_n low for 1 cycle at address 200 -> o_busy and o_w_en go 0 at the next cycle, no o_ot_valid, o_ot_fc stays 0.
- Random signed weights and features vs a reference model, 100 vectors -> exact score and argmax match.

Source files
------------

// File: rtl/fc_classifier_seq_pkg.sv
// Shared sizing and state encoding for the sequential fully-connected classifier.
// No logic: constants, derived widths and the controller state type only.
// Feature and weight geometry match the upstream CNN core (CI channels of 4x4 pooled words).
package fc_classifier_seq_pkg;

    localparam int CI      = 3;                  // input channels from the pooling stage
    localparam int IN_W    = 32;                 // pooled feature word, unsigned
    localparam int W_W     = 8;                  // weight, signed two's complement
    localparam int NUM_OUT = 10;                 // number of classes
    localparam int FC_IN   = CI * 16;            // dot-product length
    localparam int ACC_W   = 48;                 // accumulator / score width, signed
    localparam int TOTAL   = NUM_OUT * FC_IN;    // weight ROM depth
    localparam int ADDR_W  = $clog2(TOTAL);
    localparam int CLS_W   = $clog2(NUM_OUT);
    localparam int IDX_W   = $clog2(FC_IN);
    localparam int FMAP_W  = FC_IN * IN_W;
    localparam int PROD_W  = IN_W + W_W;         // signed product width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fc_mac.sv
// Registered signed multiply-accumulate: unsigned feature x signed weight, with first-term load.
// Latency: acc register updates on the enabled edge; sum_o is the combinational next value.
// Backpressure: none; accumulates on every cycle en_i is high.
// Ports: clk, reset_n (sync, active-low), en_i, first_i, feat_i, w_i -> sum_o (acc next value).
module fc_mac
    import fc_classifier_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en_i,
    input  logic                    first_i,
    input  logic [IN_W-1:0]         feat_i,
    input  logic [W_W-1:0]          w_i,
    output logic signed [ACC_W-1:0] sum_o
);

    // Feature gets a zero sign bit so the multiply is fully signed; the true
    // value always fits PROD_W bits, the extra bit is only a sign copy.
    logic signed [PROD_W:0]    prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;

    assign prod     = $signed({1'b0, feat_i}) * $signed(w_i);
    assign prod_ext = ACC_W'(prod);

    // First term of a new output replaces the stale sum instead of adding to it.
    assign acc_d = first_i ? prod_ext : (acc_q + prod_ext);
    assign sum_o = acc_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fc_classifier_seq.sv
// Sequential fully-connected classifier: NUM_OUT dot products of the pooled vector, one MAC per clock, plus argmax.
// Latency: results and o_ot_valid appear NUM_OUT*FC_IN+1 cycles after the capture edge.
// Backpressure: none; input pulses arriving while o_busy is high are dropped.
// Ports: clk, reset_n (sync, active-low), i_in_valid/i_in_fmap in; o_w_en/o_w_addr/i_w_data to the
// synchronous weight ROM (data one cycle after address); o_busy, o_ot_valid, o_ot_fc, o_ot_class out.
module fc_classifier_seq
    import fc_classifier_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_in_valid,
    input  logic [FMAP_W-1:0]        i_in_fmap,
    output logic                     o_busy,
    output logic                     o_w_en,
    output logic [ADDR_W-1:0]        o_w_addr,
    input  logic [W_W-1:0]           i_w_data,
    output logic                     o_ot_valid,
    output logic [NUM_OUT*ACC_W-1:0] o_ot_fc,
    output logic [CLS_W-1:0]         o_ot_class
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FC_IN - 1);
    localparam logic [CLS_W-1:0]  LAST_OUT  = CLS_W'(NUM_OUT - 1);

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q;
    logic [IDX_W-1:0]          idx_q;
    logic [CLS_W-1:0]          o_q;
    logic [FMAP_W-1:0]         fmap_q;

    // Tag of the ROM word currently on i_w_data (address issued last cycle).
    logic                      rd_vld_q;
    logic [IDX_W-1:0]          rd_idx_q;
    logic [CLS_W-1:0]          rd_o_q;

    logic signed [ACC_W-1:0]   score_q [NUM_OUT];
    logic signed [ACC_W-1:0]   best_q, best_d;
    logic [CLS_W-1:0]          best_idx_q, best_idx_d;
    logic [NUM_OUT*ACC_W-1:0]  ot_fc_q, fc_pack;
    logic [CLS_W-1:0]          ot_class_q;

    logic                      accept;
    logic                      last_term;
    logic                      final_term;
    logic signed [ACC_W-1:0]   mac_sum;
    logic [IN_W-1:0]           mac_feat;

    // A new vector is taken when idle, or in the result cycle for back-to-back runs.
    assign accept = i_in_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_in_valid) state_d = ST_RUN;
            ST_RUN:   if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = i_in_valid ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign mac_feat   = fmap_q[IN_W*rd_idx_q +: IN_W];
    assign last_term  = rd_vld_q && (rd_idx_q == LAST_IDX);
    assign final_term = last_term && (rd_o_q == LAST_OUT);

    fc_mac u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (rd_vld_q),
        .first_i (rd_idx_q == '0),
        .feat_i  (mac_feat),
        .w_i     (i_w_data),
        .sum_o   (mac_sum)
    );

    // Running argmax: score 0 seeds it, later scores win only if strictly greater,
    // so ties keep the lower class index.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        if (rd_o_q == '0) begin
            best_d     = mac_sum;
            best_idx_d = '0;
        end else if (mac_sum > best_q) begin
            best_d     = mac_sum;
            best_idx_d = rd_o_q;
        end
    end

    // The score finishing this edge is taken straight from the MAC so the result
    // bank publishes on the same edge as the final accumulation.
    always_comb begin
        fc_pack = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            fc_pack[ACC_W*o +: ACC_W] = (rd_o_q == CLS_W'(o)) ? mac_sum : score_q[o];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            idx_q      <= '0;
            o_q        <= '0;
            fmap_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            rd_o_q     <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            ot_fc_q    <= '0;
            ot_class_q <= '0;
            for (int o = 0; o < NUM_OUT; o++) begin
                score_q[o] <= '0;
            end
        end else begin
            state_q <= state_d;

            if (accept) begin
                fmap_q <= i_in_fmap;
            end

            // Address walks the whole ROM without bubbles; idx/o track it.
            if (state_q == ST_RUN) begin
                if (addr_q == LAST_ADDR) begin
                    addr_q <= '0;
                    idx_q  <= '0;
                    o_q    <= '0;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        o_q   <= o_q + CLS_W'(1);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
            end

            rd_vld_q <= (state_q == ST_RUN);
            rd_idx_q <= idx_q;
            rd_o_q   <= o_q;

            if (last_term) begin
                for (int o = 0; o < NUM_OUT; o++) begin
                    if (rd_o_q == CLS_W'(o)) begin
                        score_q[o] <= mac_sum;
                    end
                end
                best_q     <= best_d;
                best_idx_q <= best_idx_d;
            end

            if (final_term) begin
                ot_fc_q    <= fc_pack;
                ot_class_q <= best_idx_d;
            end
        end
    end

    assign o_busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_w_en     = (state_q == ST_RUN);
    assign o_w_addr   = (state_q == ST_RUN) ? addr_q : '0;
    assign o_ot_valid = (state_q == ST_DONE);
    assign o_ot_fc    = ot_fc_q;
    assign o_ot_class = ot_class_q;

endmodule

// File: tb/tb_fc_classifier_seq.sv
module tb_fc_classifier_seq;
    import fc_classifier_seq_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     i_in_valid;
    logic [FMAP_W-1:0]        i_in_fmap;
    logic                     o_busy;
    logic                     o_w_en;
    logic [ADDR_W-1:0]        o_w_addr;
    logic [W_W-1:0]           i_w_data;
    logic                     o_ot_valid;
    logic [NUM_OUT*ACC_W-1:0] o_ot_fc;
    logic [CLS_W-1:0]         o_ot_class;

    always #5 clk = ~clk;

    fc_classifier_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_in_valid (i_in_valid),
        .i_in_fmap  (i_in_fmap),
        .o_busy     (o_busy),
        .o_w_en     (o_w_en),
        .o_w_addr   (o_w_addr),
        .i_w_data   (i_w_data),
        .o_ot_valid (o_ot_valid),
        .o_ot_fc    (o_ot_fc),
        .o_ot_class (o_ot_class)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int e0    = 0;

    logic [W_W-1:0]    rom  [TOTAL];
    logic [IN_W-1:0]   feat [FC_IN];
    logic [FMAP_W-1:0] fmap;
    longint            exp_sc [NUM_OUT];
    int                exp_cls;
    int                addr_log [$];
    bit                w_en_seen;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous weight ROM: data valid the cycle after the address edge.
    always @(posedge clk) begin
        if (o_w_en === 1'b1) i_w_data <= rom[o_w_addr];
    end

    always @(negedge clk) begin
        if (o_w_en === 1'b1) begin
            addr_log.push_back(int'(o_w_addr));
            w_en_seen = 1'b1;
        end
    end

    task automatic pack_fmap();
        fmap = '0;
        for (int i = 0; i < FC_IN; i++) fmap[IN_W*i +: IN_W] = feat[i];
    endtask

    task automatic compute_ref();
        longint s;
        for (int o = 0; o < NUM_OUT; o++) begin
            s = 0;
            for (int i = 0; i < FC_IN; i++) begin
                s += longint'($signed(rom[o*FC_IN+i])) * longint'(feat[i]);
            end
            exp_sc[o] = s;
        end
        exp_cls = 0;
        for (int o = 1; o < NUM_OUT; o++) begin
            if (exp_sc[o] > exp_sc[exp_cls]) exp_cls = o;
        end
    endtask

    // Called at a negedge; the following posedge is the capture edge.
    task automatic start_run(input logic [FMAP_W-1:0] fm);
        addr_log.delete();
        i_in_valid = 1'b1;
        i_in_fmap  = fm;
        @(negedge clk);
        e0         = cyc;
        i_in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int k = 0; k < 700 && !ok; k++) begin
            @(negedge clk);
            if (o_ot_valid === 1'b1) begin
                ok  = 1'b1;
                lat = cyc - e0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        w_en_seen = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_cmp++; if (o_w_en !== 1'b0) begin n_bad++; $display("FAIL reset_w_en: got %b expected 0", o_w_en); end
        n_cmp++; if (o_w_addr !== '0) begin n_bad++; $display("FAIL reset_w_addr: got %0d expected 0", o_w_addr); end
        n_cmp++; if (o_ot_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", o_ot_valid); end
        n_cmp++; if (o_ot_fc !== '0) begin n_bad++; $display("FAIL reset_fc: got %h expected 0", o_ot_fc); end
        n_cmp++; if (o_ot_class !== '0) begin n_bad++; $display("FAIL reset_class: got %0d expected 0", o_ot_class); end
        n_cmp++; if (w_en_seen !== 1'b0) begin n_bad++; $display("FAIL reset_w_en_seen: got %b expected 0", w_en_seen); end
    endtask

    task automatic test_ones();
        int lat; bit ok; int gaps;
        logic [ACC_W-1:0] got;
        for (int o = 0; o < NUM_OUT; o++)
            for (int i = 0; i < FC_IN; i++) rom[o*FC_IN+i] = W_W'(o);
        for (int i = 0; i < FC_IN; i++) feat[i] = 32'd1;
        pack_fmap();
        start_run(fmap);
        wait_valid(lat, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ones_timeout: got no valid expected valid"); end
        n_cmp++; if (lat != TOTAL + 1) begin n_bad++; $display("FAIL ones_latency: got %0d expected %0d", lat, TOTAL + 1); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL ones_busy_in_valid: got %b expected 0", o_busy); end
        for (int o = 0; o < NUM_OUT; o++) begin
            got = o_ot_fc[ACC_W*o +: ACC_W];
            n_cmp++;
            if (got !== ACC_W'(48 * o)) begin
                n_bad++; $display("FAIL ones_score%0d: got %0d expected %0d", o, $signed(got), 48 * o);
            end
        end
        n_cmp++; if (o_ot_class !== CLS_W'(9)) begin n_bad++; $display("FAIL ones_class: got %0d expected 9", o_ot_class); end
        gaps = 0;
        for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) gaps++;
        n_cmp++; if (addr_log.size() != TOTAL || gaps != 0) begin
            n_bad++; $display("FAIL ones_addr_seq: got %0d addrs %0d out of order expected %0d in order", addr_log.size(), gaps, TOTAL);
        end
        @(negedge clk);
        n_cmp++; if (o_ot_valid !== 1'b0) begin n_bad++; $display("FAIL ones_valid_pulse: got %b expected 0", o_ot_valid); end
        n_cmp++; if (o_ot_class !== CLS_W'(9)) begin n_bad++; $display("FAIL ones_hold_class: got %0d expected 9", o_ot_class); end
    endtask

    task automatic test_neg_max();
        int lat; bit ok;
        logic [ACC_W-1:0] got;
        longint want = -64'sd26388279060480;
        for (int a = 0; a < TOTAL; a++) rom[a] = 8'h80;
        for (int i = 0; i < FC_IN; i++) feat[i] = 32'hFFFF_FFFF;
        pack_fmap();
        start_run(fmap);
        wait_valid(lat, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL neg_timeout: got no valid expected valid"); end
        for (int o = 0; o < NUM_OUT; o++) begin
            got = o_ot_fc[ACC_W*o +: ACC_W];
            n_cmp++;
            if (got !== want[ACC_W-1:0]) begin
                n_bad++; $display("FAIL neg_score%0d: got %0d expected %0d", o, $signed(got), want);
            end
        end
        n_cmp++; if (o_ot_class !== '0) begin n_bad++; $display("FAIL neg_class_tie: got %0d expected 0", o_ot_class); end
    endtask

    task automatic test_back_to_back();
        int lat; bit ok;
        logic [ACC_W-1:0] got;
        longint expa [NUM_OUT];
        int expa_cls;
        logic [FMAP_W-1:0] fma, fmb;
        for (int a = 0; a < TOTAL; a++) rom[a] = W_W'((a * 37 + 11) % 256);
        for (int i = 0; i < FC_IN; i++) feat[i] = 32'(i * 1000 + 7);
        pack_fmap(); fma = fmap;
        compute_ref();
        expa = exp_sc; expa_cls = exp_cls;
        for (int i = 0; i < FC_IN; i++) feat[i] = 32'hF000_0000 + 32'(i * 3);
        pack_fmap(); fmb = fmap;
        start_run(fma);
        repeat (100) @(negedge clk);
        n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_mid: got %b expected 1", o_busy); end
        i_in_valid = 1'b1; i_in_fmap = fmb;
        @(negedge clk);
        i_in_valid = 1'b0;
        wait_valid(lat, ok);
        n_cmp++; if (!ok || lat != TOTAL + 1) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, TOTAL + 1); end
        for (int o = 0; o < NUM_OUT; o++) begin
            got = o_ot_fc[ACC_W*o +: ACC_W];
            n_cmp++;
            if (got !== expa[o][ACC_W-1:0]) begin
                n_bad++; $display("FAIL b2b_first_score%0d: got %0d expected %0d", o, $signed(got), expa[o]);
            end
        end
        n_cmp++; if (o_ot_class !== CLS_W'(expa_cls)) begin n_bad++; $display("FAIL b2b_first_class: got %0d expected %0d", o_ot_class, expa_cls); end
        compute_ref();
        start_run(fmb);
        wait_valid(lat, ok);
        n_cmp++; if (!ok || lat != TOTAL + 1) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, TOTAL + 1); end
        for (int o = 0; o < NUM_OUT; o++) begin
            got = o_ot_fc[ACC_W*o +: ACC_W];
            n_cmp++;
            if (got !== exp_sc[o][ACC_W-1:0]) begin
                n_bad++; $display("FAIL b2b_second_score%0d: got %0d expected %0d", o, $signed(got), exp_sc[o]);
            end
        end
        n_cmp++; if (o_ot_class !== CLS_W'(exp_cls)) begin n_bad++; $display("FAIL b2b_second_class: got %0d expected %0d", o_ot_class, exp_cls); end
    endtask

    task automatic test_reset_mid();
        bit hit; bit vseen;
        for (int i = 0; i < FC_IN; i++) feat[i] = 32'(i + 1);
        pack_fmap();
        start_run(fmap);
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            if (o_w_addr === ADDR_W'(200)) hit = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL rstmid_reach200: got no addr 200 expected addr 200"); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
        n_cmp++; if (o_w_en !== 1'b0) begin n_bad++; $display("FAIL rstmid_w_en: got %b expected 0", o_w_en); end
        vseen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (o_ot_valid !== 1'b0) vseen = 1'b1;
        end
        n_cmp++; if (vseen) begin n_bad++; $display("FAIL rstmid_no_valid: got valid expected none"); end
        n_cmp++; if (o_ot_fc !== '0) begin n_bad++; $display("FAIL rstmid_fc: got %h expected 0", o_ot_fc); end
        n_cmp++; if (o_ot_class !== '0) begin n_bad++; $display("FAIL rstmid_class: got %0d expected 0", o_ot_class); end
    endtask

    task automatic test_random();
        int lat; bit ok; int bad_v;
        logic [ACC_W-1:0] got;
        for (int v = 0; v < 100; v++) begin
            for (int a = 0; a < TOTAL; a++) rom[a] = W_W'($urandom_range(0, 255));
            for (int i = 0; i < FC_IN; i++) feat[i] = $urandom();
            pack_fmap();
            compute_ref();
            start_run(fmap);
            wait_valid(lat, ok);
            n_cmp++; if (!ok || lat != TOTAL + 1) begin n_bad++; $display("FAIL rand%0d_latency: got %0d expected %0d", v, lat, TOTAL + 1); end
            bad_v = 0;
            for (int o = 0; o < NUM_OUT; o++) begin
                got = o_ot_fc[ACC_W*o +: ACC_W];
                if (got !== exp_sc[o][ACC_W-1:0]) begin
                    bad_v++;
                    $display("FAIL rand%0d_score%0d: got %0d expected %0d", v, o, $signed(got), exp_sc[o]);
                end
            end
            n_cmp++; if (bad_v != 0) n_bad++;
            n_cmp++; if (o_ot_class !== CLS_W'(exp_cls)) begin n_bad++; $display("FAIL rand%0d_class: got %0d expected %0d", v, o_ot_class, exp_cls); end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        i_in_valid = 1'b0;
        i_in_fmap  = '0;
        for (int a = 0; a < TOTAL; a++) rom[a] = '0;
        @(negedge clk);
        test_reset();
        test_ones();
        test_neg_max();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
